// File: rtl/instruction_ram_arbiter.sv
// instruction_ram_arbiter: two-master arbiter (instruction fetch, loader) in
// front of a single-port 32-bit instruction RAM with one-cycle read latency.
// Fetch has priority; the loader may optionally be protected from starvation
// by defining INSTR_ARB_STARVE_GUARD_EN.
module instruction_ram_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    // fetch master (read-only)
    input  logic [ADDR_W-1:0] f_address,
    input  logic              f_read,
    output logic              f_waitrequest,
    output logic [31:0]       f_readdata,
    output logic              f_readdatavalid,
    // loader master
    input  logic [ADDR_W-1:0] l_address,
    input  logic              l_read,
    input  logic              l_write,
    input  logic [31:0]       l_writedata,
    input  logic [3:0]        l_byteenable,
    input  logic              l_debugaccess,
    output logic              l_waitrequest,
    output logic [31:0]       l_readdata,
    output logic              l_readdatavalid,
    // RAM side
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    output logic              m_debugaccess,
    input  logic [31:0]       m_readdata,
    // status
    output logic              wr_blocked
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_ready;
    logic        r_rd_pend;
    logic        r_wr_blocked;
    logic [31:0] r_f_hold;
    logic [31:0] r_l_hold;

    logic w_active;
    logic w_l_req;
    logic w_starve;
    logic w_grant_f;
    logic w_grant_l;
    logic w_rd_grant;

    // No grants while in reset or in the first cycle after release.
    assign w_active = reset_n & r_ready;
    // A loader read+write pair is a write; either one is a request.
    assign w_l_req  = l_read | l_write;

`ifdef INSTR_ARB_STARVE_GUARD_EN
    logic [7:0] r_starve_cnt;

    assign w_starve = (r_starve_cnt == 8'(STARVE_LIMIT));

    // Count fetch wins the loader has waited through; a loader win or an idle loader restarts it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (!w_l_req || w_grant_l) begin
            r_starve_cnt <= '0;
        end else if (w_grant_f) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end
`else
    // Never true for a legal limit: strict fetch priority.
    assign w_starve = (STARVE_LIMIT < 1);
`endif

    assign w_grant_f  = w_active & f_read & ~(w_l_req & w_starve);
    assign w_grant_l  = w_active & w_l_req & (~f_read | w_starve);
    assign w_rd_grant = w_grant_f | (w_grant_l & ~l_write);

    assign f_waitrequest = ~w_grant_f;
    assign l_waitrequest = ~w_grant_l;

    // Owner register: remembers who used the RAM in the previous cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next owner follows this cycle's grant.
    always_comb begin
        w_state_next = ST_IDLE;
        if (w_grant_f) begin
            w_state_next = ST_FETCH;
        end else if (w_grant_l) begin
            w_state_next = ST_LOAD;
        end
    end

    // Post-reset ready flag, read-response pending bit and sticky blocked-write flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ready      <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_wr_blocked <= 1'b0;
        end else begin
            r_ready   <= 1'b1;
            r_rd_pend <= w_rd_grant;
            if (w_grant_l && l_write && !l_debugaccess) begin
                r_wr_blocked <= 1'b1;
            end
        end
    end

    // The pending read belongs to whoever owned the RAM last cycle.
    assign f_readdatavalid = reset_n & r_rd_pend & (r_state == ST_FETCH);
    assign l_readdatavalid = reset_n & r_rd_pend & (r_state == ST_LOAD);

    // Keep each master's last delivered word so readdata holds between responses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_f_hold <= '0;
            r_l_hold <= '0;
        end else begin
            if (f_readdatavalid) begin
                r_f_hold <= m_readdata;
            end
            if (l_readdatavalid) begin
                r_l_hold <= m_readdata;
            end
        end
    end

    assign f_readdata = f_readdatavalid ? m_readdata : (reset_n ? r_f_hold : 32'h0);
    assign l_readdata = l_readdatavalid ? m_readdata : (reset_n ? r_l_hold : 32'h0);
    assign wr_blocked = reset_n & r_wr_blocked;

    // RAM-side mux: present the granted master's command, otherwise an idle bus.
    always_comb begin
        m_address     = '0;
        m_chipselect  = 1'b0;
        m_write       = 1'b0;
        m_writedata   = '0;
        m_byteenable  = 4'hF;
        m_debugaccess = 1'b0;
        if (w_grant_f) begin
            m_address    = f_address;
            m_chipselect = 1'b1;
        end else if (w_grant_l) begin
            m_address     = l_address;
            m_chipselect  = 1'b1;
            m_write       = l_write;
            m_writedata   = l_writedata;
            m_byteenable  = l_byteenable;
            m_debugaccess = l_debugaccess;
        end
    end

endmodule

// File: tb/tb_instruction_ram_arbiter.sv
// Testbench for instruction_ram_arbiter: directed scenarios plus a randomized
// run checked against a cycle-level reference model of the arbitration rules.
module tb_instruction_ram_arbiter;
    localparam int ADDR_W       = 13;
    localparam int STARVE_LIMIT = 8;
`ifdef INSTR_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] f_address;
    logic              f_read;
    logic              f_waitrequest;
    logic [31:0]       f_readdata;
    logic              f_readdatavalid;
    logic [ADDR_W-1:0] l_address;
    logic              l_read;
    logic              l_write;
    logic [31:0]       l_writedata;
    logic [3:0]        l_byteenable;
    logic              l_debugaccess;
    logic              l_waitrequest;
    logic [31:0]       l_readdata;
    logic              l_readdatavalid;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic [3:0]        m_byteenable;
    logic              m_debugaccess;
    logic [31:0]       m_readdata;
    logic              wr_blocked;

    always #5 clk = ~clk;

    instruction_ram_arbiter #(
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .f_address      (f_address),
        .f_read         (f_read),
        .f_waitrequest  (f_waitrequest),
        .f_readdata     (f_readdata),
        .f_readdatavalid(f_readdatavalid),
        .l_address      (l_address),
        .l_read         (l_read),
        .l_write        (l_write),
        .l_writedata    (l_writedata),
        .l_byteenable   (l_byteenable),
        .l_debugaccess  (l_debugaccess),
        .l_waitrequest  (l_waitrequest),
        .l_readdata     (l_readdata),
        .l_readdatavalid(l_readdatavalid),
        .m_address      (m_address),
        .m_chipselect   (m_chipselect),
        .m_write        (m_write),
        .m_writedata    (m_writedata),
        .m_byteenable   (m_byteenable),
        .m_debugaccess  (m_debugaccess),
        .m_readdata     (m_readdata),
        .wr_blocked     (wr_blocked)
    );

    function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // RAM: one-cycle read latency; writes without debugaccess are ignored.
    bit [31:0] ram [0:(1<<ADDR_W)-1];
    bit [31:0] ram_q;
    always @(posedge clk) begin
        if (m_chipselect && m_write && m_debugaccess)
            ram[m_address] <= be_merge(ram[m_address], m_writedata, m_byteenable);
        if (m_chipselect && !m_write)
            ram_q <= ram[m_address];
    end
    assign m_readdata = ram_q;

    // Reference model state
    bit          exp_ready;
    int          streak;
    bit          exp_vf;
    bit          exp_vl;
    logic [31:0] exp_data   = '0;
    logic [31:0] exp_last_f = '0;
    logic [31:0] exp_last_l = '0;
    bit          exp_blocked;
    bit [31:0]   exp_mem [0:(1<<ADDR_W)-1];

    int n_vec = 0;
    int n_bad = 0;

    // {loader granted, fetch granted} for the current inputs.
    function automatic logic [1:0] exp_grant();
        logic act, lreq, gf, gl;
        act  = reset_n && exp_ready;
        lreq = l_read || l_write;
        gf   = act && f_read && !(GUARD && lreq && streak == STARVE_LIMIT);
        gl   = act && lreq && !gf;
        return {gl, gf};
    endfunction

    // Advance the model by one clock using this cycle's inputs.
    task automatic commit();
        logic [1:0] g;
        if (!reset_n) begin
            exp_ready   = 1'b0;
            streak      = 0;
            exp_vf      = 1'b0;
            exp_vl      = 1'b0;
            exp_last_f  = '0;
            exp_last_l  = '0;
            exp_blocked = 1'b0;
        end else begin
            g = exp_grant();
            if (exp_vf) exp_last_f = exp_data;
            if (exp_vl) exp_last_l = exp_data;
            exp_vf = g[0];
            exp_vl = g[1] && !l_write;
            if (g[0]) exp_data = exp_mem[f_address];
            else if (g[1] && !l_write) exp_data = exp_mem[l_address];
            if (g[1] && l_write) begin
                if (l_debugaccess) exp_mem[l_address] = be_merge(exp_mem[l_address], l_writedata, l_byteenable);
                else exp_blocked = 1'b1;
            end
            if (!(l_read || l_write) || g[1]) streak = 0;
            else if (g[0]) streak = streak + 1;
            exp_ready = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic set_idle();
        f_read        = 1'b0;
        f_address     = '0;
        l_read        = 1'b0;
        l_write       = 1'b0;
        l_address     = '0;
        l_writedata   = '0;
        l_byteenable  = 4'hF;
        l_debugaccess = 1'b1;
    endtask

    task automatic ldr_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be,
                             input logic dbg);
        l_write = 1'b1; l_address = a; l_writedata = d; l_byteenable = be; l_debugaccess = dbg;
        tick();
        set_idle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_idle();
        f_read = 1'b1; l_read = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_vec++; if (f_waitrequest !== 1'b1) begin n_bad++; $display("FAIL rst_f_wait: got %b want 1", f_waitrequest); end
        n_vec++; if (l_waitrequest !== 1'b1) begin n_bad++; $display("FAIL rst_l_wait: got %b want 1", l_waitrequest); end
        n_vec++; if (m_chipselect !== 1'b0 || m_write !== 1'b0) begin n_bad++; $display("FAIL rst_m_cs_wr: got %b%b want 00", m_chipselect, m_write); end
        n_vec++; if (f_readdatavalid !== 1'b0 || l_readdatavalid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b%b want 00", f_readdatavalid, l_readdatavalid); end
        n_vec++; if (f_readdata !== 32'h0 || l_readdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h %h want 0 0", f_readdata, l_readdata); end
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++; if (f_waitrequest !== 1'b1 || l_waitrequest !== 1'b1) begin n_bad++; $display("FAIL post_rst_wait: got %b%b want 11", f_waitrequest, l_waitrequest); end
        n_vec++; if (m_chipselect !== 1'b0) begin n_bad++; $display("FAIL post_rst_cs: got %b want 0", m_chipselect); end
        n_vec++; if (f_readdatavalid !== 1'b0 || l_readdatavalid !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid: got %b%b want 00", f_readdatavalid, l_readdatavalid); end
        tick();
        @(negedge clk);
        n_vec++; if (f_waitrequest !== 1'b0 || l_waitrequest !== 1'b1) begin n_bad++; $display("FAIL first_grant: got f%b l%b want f0 l1", f_waitrequest, l_waitrequest); end
        set_idle();
        tick();
        tick();
    endtask

    task automatic test_fetch_read();
        ldr_write(13'h0010, 32'hDEADBEEF, 4'hF, 1'b1);
        f_read = 1'b1; f_address = 13'h0010;
        @(negedge clk);
        n_vec++; if (f_waitrequest !== 1'b0) begin n_bad++; $display("FAIL fetch_wait: got %b want 0", f_waitrequest); end
        n_vec++; if (m_address !== 13'h0010 || m_chipselect !== 1'b1) begin n_bad++; $display("FAIL fetch_addr: got %h cs %b want 0010 cs 1", m_address, m_chipselect); end
        tick();
        set_idle();
        @(negedge clk);
        n_vec++; if (f_readdatavalid !== 1'b1) begin n_bad++; $display("FAIL fetch_valid: got %b want 1", f_readdatavalid); end
        n_vec++; if (f_readdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fetch_data: got %h want deadbeef", f_readdata); end
        n_vec++; if (l_readdatavalid !== 1'b0) begin n_bad++; $display("FAIL fetch_l_valid: got %b want 0", l_readdatavalid); end
        tick();
        @(negedge clk);
        n_vec++; if (f_readdatavalid !== 1'b0 || f_readdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL fetch_hold: got v%b %h want v0 deadbeef", f_readdatavalid, f_readdata); end
        tick();
    endtask

    task automatic test_simultaneous();
        ldr_write(13'h0001, 32'hA1A1A1A1, 4'hF, 1'b1);
        ldr_write(13'h0002, 32'hB2B2B2B2, 4'hF, 1'b1);
        f_read = 1'b1; f_address = 13'h0001;
        l_read = 1'b1; l_address = 13'h0002;
        @(negedge clk);
        n_vec++; if (f_waitrequest !== 1'b0 || l_waitrequest !== 1'b1) begin n_bad++; $display("FAIL sim_n_grant: got f%b l%b want f0 l1", f_waitrequest, l_waitrequest); end
        tick();
        f_read = 1'b0;
        @(negedge clk);
        n_vec++; if (l_waitrequest !== 1'b0 || m_address !== 13'h0002) begin n_bad++; $display("FAIL sim_n1_grant: got l%b addr %h want l0 addr 0002", l_waitrequest, m_address); end
        n_vec++; if (f_readdatavalid !== 1'b1 || f_readdata !== 32'hA1A1A1A1) begin n_bad++; $display("FAIL sim_f_resp: got v%b %h want v1 a1a1a1a1", f_readdatavalid, f_readdata); end
        tick();
        set_idle();
        @(negedge clk);
        n_vec++; if (l_readdatavalid !== 1'b1 || l_readdata !== 32'hB2B2B2B2) begin n_bad++; $display("FAIL sim_l_resp: got v%b %h want v1 b2b2b2b2", l_readdatavalid, l_readdata); end
        n_vec++; if (f_readdatavalid !== 1'b0) begin n_bad++; $display("FAIL sim_f_quiet: got %b want 0", f_readdatavalid); end
        tick();
    endtask

    task automatic test_loader_write();
        l_write = 1'b1; l_address = 13'h1FFF; l_writedata = 32'h12345678; l_byteenable = 4'b0011; l_debugaccess = 1'b1;
        @(negedge clk);
        n_vec++; if (m_write !== 1'b1 || m_byteenable !== 4'b0011 || m_debugaccess !== 1'b1) begin n_bad++; $display("FAIL lw_cmd: got wr%b be%b dbg%b want wr1 be0011 dbg1", m_write, m_byteenable, m_debugaccess); end
        n_vec++; if (m_address !== 13'h1FFF || m_writedata !== 32'h12345678) begin n_bad++; $display("FAIL lw_addr_data: got %h %h want 1fff 12345678", m_address, m_writedata); end
        tick();
        set_idle();
        @(negedge clk);
        n_vec++; if (wr_blocked !== 1'b0 || l_readdatavalid !== 1'b0) begin n_bad++; $display("FAIL lw_after: got blk%b v%b want blk0 v0", wr_blocked, l_readdatavalid); end
        l_write = 1'b1; l_address = 13'h1FFF; l_writedata = 32'hCAFEF00D; l_byteenable = 4'hF; l_debugaccess = 1'b0;
        @(negedge clk);
        n_vec++; if (m_debugaccess !== 1'b0 || m_write !== 1'b1) begin n_bad++; $display("FAIL lw_nodbg_cmd: got dbg%b wr%b want dbg0 wr1", m_debugaccess, m_write); end
        tick();
        set_idle();
        l_read = 1'b1; l_address = 13'h1FFF;
        @(negedge clk);
        n_vec++; if (wr_blocked !== 1'b1) begin n_bad++; $display("FAIL lw_blocked: got %b want 1", wr_blocked); end
        tick();
        set_idle();
        @(negedge clk);
        n_vec++; if (l_readdatavalid !== 1'b1 || l_readdata !== 32'h00005678) begin n_bad++; $display("FAIL lw_readback: got v%b %h want v1 00005678", l_readdatavalid, l_readdata); end
        repeat (3) tick();
        @(negedge clk);
        n_vec++; if (wr_blocked !== 1'b1) begin n_bad++; $display("FAIL lw_sticky: got %b want 1", wr_blocked); end
        tick();
    endtask

    task automatic test_starve();
        int l_grants;
        bit exp_l;
        l_grants = 0;
        f_read = 1'b1; f_address = 13'h0003;
        l_read = 1'b1; l_address = 13'h0004;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            exp_l = GUARD && (k % (STARVE_LIMIT + 1) == STARVE_LIMIT);
            if (!l_waitrequest) l_grants++;
            n_vec++; if (l_waitrequest !== !exp_l || f_waitrequest !== exp_l) begin n_bad++; $display("FAIL starve_k%0d: got f%b l%b want f%b l%b", k, f_waitrequest, l_waitrequest, exp_l, !exp_l); end
            tick();
        end
        n_vec++; if (l_grants != (GUARD ? 36 / (STARVE_LIMIT + 1) : 0)) begin n_bad++; $display("FAIL starve_count: got %0d want %0d", l_grants, GUARD ? 36 / (STARVE_LIMIT + 1) : 0); end
        set_idle();
        tick();
    endtask

    task automatic test_reset_midstream();
        f_read = 1'b1; f_address = 13'h0010;
        @(negedge clk);
        n_vec++; if (f_waitrequest !== 1'b0) begin n_bad++; $display("FAIL mid_grant: got %b want 0", f_waitrequest); end
        tick();
        reset_n = 1'b0;
        l_write = 1'b1; l_debugaccess = 1'b0; l_address = 13'h0005;
        @(negedge clk);
        n_vec++; if (f_readdatavalid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", f_readdatavalid); end
        n_vec++; if (f_waitrequest !== 1'b1 || l_waitrequest !== 1'b1) begin n_bad++; $display("FAIL mid_rst_wait: got %b%b want 11", f_waitrequest, l_waitrequest); end
        n_vec++; if (wr_blocked !== 1'b0) begin n_bad++; $display("FAIL mid_rst_blk: got %b want 0", wr_blocked); end
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        n_vec++; if (f_readdatavalid !== 1'b0 || f_readdata !== 32'h0) begin n_bad++; $display("FAIL mid_post_resp: got v%b %h want v0 0", f_readdatavalid, f_readdata); end
        n_vec++; if (f_waitrequest !== 1'b1 || l_waitrequest !== 1'b1 || wr_blocked !== 1'b0) begin n_bad++; $display("FAIL mid_post_wait: got f%b l%b blk%b want 1 1 0", f_waitrequest, l_waitrequest, wr_blocked); end
        set_idle();
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [1:0]  g;
        logic        ev_f, ev_l;
        logic [31:0] ed_f, ed_l;
        for (int c = 0; c < 400; c++) begin
            f_read        = ($urandom_range(0, 9) < 7);
            f_address     = 13'($urandom_range(0, 15));
            l_read        = 1'($urandom_range(0, 1));
            l_write       = ($urandom_range(0, 3) == 0);
            l_address     = 13'($urandom_range(0, 15));
            l_writedata   = $urandom;
            l_byteenable  = 4'($urandom_range(0, 15));
            l_debugaccess = ($urandom_range(0, 7) != 0);
            @(negedge clk);
            g    = exp_grant();
            ev_f = exp_vf;
            ev_l = exp_vl;
            ed_f = exp_vf ? exp_data : exp_last_f;
            ed_l = exp_vl ? exp_data : exp_last_l;
            n_vec++; if (f_waitrequest !== !g[0] || l_waitrequest !== !g[1]) begin n_bad++; $display("FAIL rand_wait c%0d: got f%b l%b want f%b l%b", c, f_waitrequest, l_waitrequest, !g[0], !g[1]); end
            n_vec++; if (m_chipselect !== (g[0] | g[1]) || m_write !== (g[1] & l_write)) begin n_bad++; $display("FAIL rand_cmd c%0d: got cs%b wr%b want cs%b wr%b", c, m_chipselect, m_write, g[0] | g[1], g[1] & l_write); end
            if (g[0] | g[1]) begin
                n_vec++; if (m_address !== (g[0] ? f_address : l_address)) begin n_bad++; $display("FAIL rand_addr c%0d: got %h want %h", c, m_address, g[0] ? f_address : l_address); end
            end
            n_vec++; if (f_readdatavalid !== ev_f || f_readdata !== ed_f) begin n_bad++; $display("FAIL rand_f_resp c%0d: got v%b %h want v%b %h", c, f_readdatavalid, f_readdata, ev_f, ed_f); end
            n_vec++; if (l_readdatavalid !== ev_l || l_readdata !== ed_l) begin n_bad++; $display("FAIL rand_l_resp c%0d: got v%b %h want v%b %h", c, l_readdatavalid, l_readdata, ev_l, ed_l); end
            n_vec++; if (wr_blocked !== exp_blocked) begin n_bad++; $display("FAIL rand_blk c%0d: got %b want %b", c, wr_blocked, exp_blocked); end
            tick();
        end
        set_idle();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fetch_read();
        test_simultaneous();
        test_loader_write();
        test_starve();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
